// File: rtl/sr_serializer_if.sv
// -----------------------------------------------------------------------------
// sr_serializer_if
//   Bundles the signals between the display controller and the 74HC595-style
//   shift-register driver.
//
//   Signals:
//     i_load   controller -> serializer  single-cycle load strobe
//     i_data   controller -> serializer  parallel word (WIDTH bits)
//     o_busy   serializer -> controller  transfer in progress
//     o_sclk   serializer -> chain       shift clock
//     o_sdata  serializer -> chain       serial data
//     o_rclk   serializer -> chain       storage/latch clock pulse
//
//   Modports:
//     master   the controller side (drives load/data, observes the rest)
//     slave    the serializer side
// -----------------------------------------------------------------------------
interface sr_serializer_if #(
  parameter int WIDTH = 8
);

  logic             i_load;
  logic [WIDTH-1:0] i_data;
  logic             o_busy;
  logic             o_sclk;
  logic             o_sdata;
  logic             o_rclk;

  modport master (
    output i_load,
    output i_data,
    input  o_busy,
    input  o_sclk,
    input  o_sdata,
    input  o_rclk
  );

  modport slave (
    input  i_load,
    input  i_data,
    output o_busy,
    output o_sclk,
    output o_sdata,
    output o_rclk
  );

endinterface

// File: rtl/sr_serializer.sv
// -----------------------------------------------------------------------------
// sr_serializer
//   Parallel-to-serial driver for a 74HC595-style display chain. Each accepted
//   load shifts WIDTH bits out on o_sdata/o_sclk and then pulses o_rclk for
//   DIV cycles so the chain transfers the word to its outputs.
//
//   Parameters:
//     WIDTH      bits shifted per load (2..32)
//     DIV        i_clk cycles per sclk half-period and per rclk pulse (1..255)
//     MSB_FIRST  1: i_data[WIDTH-1] goes out first, 0: i_data[0] goes out first
//
//   Ports:
//     i_clk        clock
//     i_rst        synchronous, active-high reset
//     bus (slave)  i_load / i_data in, o_busy / o_sclk / o_sdata / o_rclk out
//
//   Timing: with the load sampled at edge 0, o_busy is high from edge 0 through
//   edge (2*WIDTH+1)*DIV. o_sdata only changes on the load edge or on the edge
//   where o_sclk falls, so it is stable for DIV cycles on both sides of every
//   sclk rise.
// -----------------------------------------------------------------------------
module sr_serializer #(
  parameter int WIDTH     = 8,
  parameter int DIV       = 2,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic           i_clk,
  input  logic           i_rst,
  sr_serializer_if.slave bus
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIT_W = $clog2(WIDTH);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_LATCH
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q,   div_d;
  logic [BIT_W-1:0] bit_q,   bit_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             busy_q,  busy_d;
  logic             sclk_q,  sclk_d;
  logic             sdata_q, sdata_d;
  logic             rclk_q,  rclk_d;

  logic [WIDTH-1:0] load_word;
  logic             div_last;
  logic             bit_last;

  assign load_word = bus.i_data;
  assign div_last  = (div_q == DIV_LAST);
  assign bit_last  = (bit_q == BIT_LAST);

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case
    // leaves one unassigned, which would otherwise infer a latch.
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    busy_d  = busy_q;
    sclk_d  = sclk_q;
    sdata_d = sdata_q;
    rclk_d  = rclk_q;

    unique case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        sclk_d = 1'b0;
        rclk_d = 1'b0;
        // o_sdata keeps whatever bit was last shifted.
        if (bus.i_load) begin
          shreg_d = load_word;
          sdata_d = MSB_FIRST ? load_word[WIDTH-1] : load_word[0];
          bit_d   = '0;
          div_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_SHIFT_LO;
        end
      end

      ST_SHIFT_LO: begin
        sclk_d = 1'b0;
        if (div_last) begin
          div_d   = '0;
          sclk_d  = 1'b1;
          state_d = ST_SHIFT_HI;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      ST_SHIFT_HI: begin
        sclk_d = 1'b1;
        if (div_last) begin
          div_d  = '0;
          sclk_d = 1'b0;
          if (bit_last) begin
            rclk_d  = 1'b1;
            state_d = ST_LATCH;
          end else begin
            // The next bit is presented on the same edge sclk falls, giving
            // a full low phase of setup before the following rise.
            bit_d = bit_q + BIT_W'(1);
            if (MSB_FIRST) begin
              shreg_d = shreg_q << 1;
              sdata_d = shreg_q[WIDTH-2];
            end else begin
              shreg_d = shreg_q >> 1;
              sdata_d = shreg_q[1];
            end
            state_d = ST_SHIFT_LO;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      ST_LATCH: begin
        rclk_d = 1'b1;
        sclk_d = 1'b0;
        if (div_last) begin
          rclk_d  = 1'b0;
          busy_d  = 1'b0;
          div_d   = '0;
          state_d = ST_IDLE;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // NOTE: the shift register is cleared along with the control state so a
      // transfer abandoned by reset leaves no stale bits behind.
      state_q <= ST_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      busy_q  <= 1'b0;
      sclk_q  <= 1'b0;
      sdata_q <= 1'b0;
      rclk_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      busy_q  <= busy_d;
      sclk_q  <= sclk_d;
      sdata_q <= sdata_d;
      rclk_q  <= rclk_d;
    end
  end

  assign bus.o_busy  = busy_q;
  assign bus.o_sclk  = sclk_q;
  assign bus.o_sdata = sdata_q;
  assign bus.o_rclk  = rclk_q;

endmodule

// File: doc/sr_serializer.md
Name: sr_serializer

Overview:
- Parallel-to-serial shift-register driver for the 74HC595-style display chain.
- Sits directly downstream of the measurement/display controller. It consumes that controller's load strobe and the muxed digit word, and returns a busy flag the controller polls before the next load.
- Per load it shifts WIDTH bits out on o_sdata/o_sclk, then pulses o_rclk to transfer the word to the chip outputs.

Parameters:
- WIDTH, 8: bits shifted per load; legal range 2..32.
- DIV, 2: i_clk cycles per sclk half-period and per rclk pulse length; legal range 1..255.
- MSB_FIRST, 1: 1 = i_data[WIDTH-1] is shifted first; 0 = i_data[0] is shifted first.

Ports:
- i_clk  input  1  clock
- i_rst  input  1  reset, synchronous, active-high
- i_load  input  1  single-cycle load strobe; sampled only in IDLE
- i_data  input  WIDTH  parallel word, captured on the accepted load
- o_busy  output  1  high from the cycle after an accepted load until the transfer completes
- o_sclk  output  1  shift clock to the chain; data is stable across its rising edge
- o_sdata  output  1  serial data
- o_rclk  output  1  storage/latch clock pulse, high for DIV cycles after the last bit

Behaviour:
- Clock and reset: i_clk is the only clock; reset is i_rst, synchronous, active-high.
- All outputs are registered. Reset values: o_busy=0, o_sclk=0, o_sdata=0, o_rclk=0. Internal state resets to IDLE, with bit_cnt and div_cnt cleared and the shift register cleared.
- Reset has priority over every other event, including mid-transfer. A transfer interrupted by reset is abandoned: no rclk pulse, and outputs return to their reset values on the next edge.
- Counter widths:
  - div_cnt counts 0..DIV-1 and is max(1, clog2(DIV)) bits wide.
  - bit_cnt counts 0..WIDTH-1 and is clog2(WIDTH) bits wide.
  - No wrap-around is allowed beyond the terminal values.
- IDLE:
  - o_busy=0, o_sclk=0, o_rclk=0; o_sdata holds its last value.
  - On i_load=1: capture i_data into shreg; o_sdata<=first bit (per MSB_FIRST); bit_cnt<=0; div_cnt<=0; o_busy<=1; go to SHIFT_LO.
- SHIFT_LO:
  - o_sclk=0.
  - If div_cnt==DIV-1: div_cnt<=0, o_sclk<=1, go to SHIFT_HI. Otherwise div_cnt++.
- SHIFT_HI:
  - o_sclk=1.
  - If div_cnt==DIV-1: div_cnt<=0, o_sclk<=0.
    - If bit_cnt==WIDTH-1: o_rclk<=1, go to LATCH.
    - Otherwise: bit_cnt++, shift shreg, o_sdata<=next bit, go to SHIFT_LO.
  - Otherwise div_cnt++.
- LATCH:
  - o_rclk=1, o_sclk=0.
  - If div_cnt==DIV-1: o_rclk<=0, o_busy<=0, div_cnt<=0, go to IDLE. Otherwise div_cnt++.
- Timing (load sampled at edge 0):
  - o_busy is high from edge 0 through edge (2*WIDTH+1)*DIV, and low after that edge.
  - With WIDTH=8 and DIV=2, busy lasts 34 cycles.
  - o_sdata changes only on the same edge where o_sclk falls, or on the load edge. It is therefore stable for DIV cycles before and DIV cycles after each sclk rise.
- Handshake:
  - Because o_busy is registered high on the edge that accepts the load, a controller that drops its load strobe and re-checks busy one cycle later always sees busy=1.
  - i_load while o_busy=1, or while in any state other than IDLE, is ignored, and i_data is not captured.
  - i_load held high continuously produces back-to-back transfers with exactly one IDLE cycle between them (busy=0 for one cycle).
- Simultaneous events:
  - i_load coinciding with the LATCH-exit edge is ignored, because the state is not yet IDLE.
  - i_load together with i_rst is ignored; reset wins.
- Exactly WIDTH rising sclk edges and one rclk pulse occur per accepted load.

Test Plan:
- Reset, then WIDTH=8, DIV=2, load i_data=8'hA5 -> sdata sampled on the 8 sclk rises reads 1,0,1,0,0,1,0,1; one rclk pulse of 2 cycles after the last sclk fall; busy high exactly 34 cycles starting the cycle after load.
- MSB_FIRST=0, load 8'h01 -> first sampled bit is 1, the remaining 7 are 0; sclk low/high phases are each 2 cycles.
- Load 8'hFF, then pulse i_load with i_data=8'h00 at cycle 10 of the transfer -> second load ignored; shifted word is 8'hFF; busy drops at cycle 34; no second transfer starts.
- Assert i_rst at cycle 15 of an 8'h3C transfer -> next cycle busy=0, sclk=0, rclk=0, sdata=0; no rclk pulse; a subsequent load of 8'hC3 shifts correctly.
- i_load held high with i_data=8'h5A, DIV=1 -> consecutive 17-cycle busy windows separated by exactly one busy=0 cycle; each window shifts 8'h5A.
- Controller-style poll: load, drop load, sample busy one cycle later -> busy=1; with DIV=1, WIDTH=2, busy lasts 5 cycles.
